// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - five-slot common-anode seven-segment scanner with frame-synchronous snapshot
// Optional cursor blink and win flash are compiled in with SEG_SCAN_BLINK_EN.
module seg_scan_driver #(
  parameter int SCAN_DIV     = 50000,
  parameter int GHOST        = 2,
  parameter int BLINK_FRAMES = 32
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [27:0] rowDisp,
  input  logic [6:0]  userNumDisp,
  input  logic [1:0]  cursorCol,
  input  logic        wpInd,
  input  logic        winInd,
  output logic [6:0]  segOut,
  output logic        dpOut,
  output logic [4:0]  anOut,
  output logic        frameTick
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [6:0] BLANK = 7'h7F;

  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic             slotEnd;
  logic             endFrame;

  logic [27:0] snapRow;
  logic [6:0]  snapUser;
  logic        snapWp;

  logic       winBlank;
  logic       curBlank;
  logic       ghost;
  logic [6:0] digit;

  assign slotEnd  = (cnt == CNT_LAST);
  assign endFrame = slotEnd && (idx == 3'd4);
  assign ghost    = int'(cnt) < GHOST;

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
      idx <= 3'd0;
    end else if (slotEnd) begin
      cnt <= '0;
      idx <= (idx == 3'd4) ? 3'd0 : idx + 3'd1;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Display data is only ever taken from these registers, so the frame never tears.
  always_ff @(posedge CLK) begin
    if (RST) begin
      snapRow  <= {4{BLANK}};
      snapUser <= BLANK;
      snapWp   <= 1'b0;
    end else if (endFrame) begin
      snapRow  <= rowDisp;
      snapUser <= userNumDisp;
      snapWp   <= wpInd;
    end
  end

`ifdef SEG_SCAN_BLINK_EN
  localparam int BC_W = $clog2(2 * BLINK_FRAMES);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(2 * BLINK_FRAMES - 1);

  logic [BC_W-1:0] bc;
  logic [1:0]      snapCursor;
  logic            snapWin;
  logic            blinkPhase;

  // bc steps on the same edge as the snapshot so the phase flips only between frames.
  always_ff @(posedge CLK) begin
    if (RST) begin
      bc         <= '0;
      snapCursor <= 2'd0;
      snapWin    <= 1'b0;
    end else if (endFrame) begin
      bc         <= (bc == BC_LAST) ? '0 : bc + BC_W'(1);
      snapCursor <= cursorCol;
      snapWin    <= winInd;
    end
  end

  assign blinkPhase = int'(bc) >= BLINK_FRAMES;
  assign winBlank   = snapWin && blinkPhase;
  assign curBlank   = !snapWin && blinkPhase && (idx == {1'b0, snapCursor});
`else
  logic unusedBlink;

  assign unusedBlink = ^{cursorCol, winInd, BLINK_FRAMES > 0};
  assign winBlank    = 1'b0;
  assign curBlank    = 1'b0;
`endif

  always_comb begin
    digit = BLANK;
    case (idx)
      3'd0:    digit = snapRow[27:21];
      3'd1:    digit = snapRow[20:14];
      3'd2:    digit = snapRow[13:7];
      3'd3:    digit = snapRow[6:0];
      3'd4:    digit = snapUser;
      default: digit = BLANK;
    endcase
    if (winBlank || curBlank) begin
      digit = BLANK;
    end
  end

  // Segments switch at the slot start while anodes stay dark for the ghost window.
  always_ff @(posedge CLK) begin
    if (RST) begin
      segOut    <= BLANK;
      dpOut     <= 1'b1;
      anOut     <= 5'h1F;
      frameTick <= 1'b0;
    end else begin
      segOut    <= digit;
      dpOut     <= !((idx == 3'd4) && snapWp && !winBlank);
      anOut     <= ghost ? 5'h1F : ~(5'b00001 << idx);
      frameTick <= endFrame;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - table-driven frame checks for seg_scan_driver
// Runs with SCAN_DIV=4, GHOST=1, BLINK_FRAMES=2; expectations follow SEG_SCAN_BLINK_EN.
module tb_seg_scan_driver;

  localparam logic [27:0] ROW_A = {7'h40, 7'h79, 7'h24, 7'h30};
  localparam logic [27:0] ROW_B = {7'h40, 7'h12, 7'h24, 7'h30};
  localparam logic [34:0] SEG_A = {7'h40, 7'h79, 7'h24, 7'h30, 7'h19};
  localparam logic [34:0] SEG_B = {7'h40, 7'h12, 7'h24, 7'h30, 7'h19};
  localparam logic [34:0] SEG_BLANK = {5{7'h7F}};

  logic        CLK;
  logic        RST;
  logic [27:0] rowDisp;
  logic [6:0]  userNumDisp;
  logic [1:0]  cursorCol;
  logic        wpInd;
  logic        winInd;
  logic [6:0]  segOut;
  logic        dpOut;
  logic [4:0]  anOut;
  logic        frameTick;

  int vectors = 0;
  int fails   = 0;

  typedef struct {
    logic [27:0] row;
    logic [27:0] mid;
    logic        doMid;
    logic [6:0]  user;
    logic [1:0]  cur;
    logic        wp;
    logic        win;
    logic [34:0] expSeg;
    logic        expDp4;
  } vecT;

  vecT vecs [8];

  seg_scan_driver #(
    .SCAN_DIV(4),
    .GHOST(1),
    .BLINK_FRAMES(2)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .rowDisp(rowDisp),
    .userNumDisp(userNumDisp),
    .cursorCol(cursorCol),
    .wpInd(wpInd),
    .winInd(winInd),
    .segOut(segOut),
    .dpOut(dpOut),
    .anOut(anOut),
    .frameTick(frameTick)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input int cyc, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, got, exp);
    end
  endtask

  task automatic checkReset(input string tag);
    check({tag, " segOut"}, -1, 32'(segOut), 32'h7F);
    check({tag, " dpOut"}, -1, 32'(dpOut), 32'h1);
    check({tag, " anOut"}, -1, 32'(anOut), 32'h1F);
    check({tag, " frameTick"}, -1, 32'(frameTick), 32'h0);
  endtask

  // One full frame, starting at a negedge just before the frame's first state edge.
  task automatic runFrame(input logic [34:0] expSeg, input logic expDp4, input logic doMid, input logic [27:0] midRow);
    logic [4:0] anLit [5];
    int slot;
    anLit = '{5'h1E, 5'h1D, 5'h1B, 5'h17, 5'h0F};
    for (int k = 0; k < 20; k++) begin
      if (doMid && k == 9) rowDisp = midRow;
      @(posedge CLK);
      @(negedge CLK);
      slot = k / 4;
      check("anOut", k, 32'(anOut), (k % 4 == 0) ? 32'h1F : 32'(anLit[slot]));
      check("segOut", k, 32'(segOut), 32'(expSeg[34 - 7 * slot -: 7]));
      check("dpOut", k, 32'(dpOut), (slot == 4) ? 32'(expDp4) : 32'h1);
      check("frameTick", k, 32'(frameTick), (k == 19) ? 32'h1 : 32'h0);
    end
  endtask

  initial begin
    logic [34:0] prevSeg;
    logic        prevDp;

    // Record i is snapshotted at the end of frame i and displayed in frame i+1 (bc = (i+1) % 4).
`ifdef SEG_SCAN_BLINK_EN
    vecs[0] = '{ROW_A, ROW_A, 1'b0, 7'h19, 2'd2, 1'b0, 1'b0, SEG_A, 1'b1};
    vecs[1] = '{ROW_A, ROW_B, 1'b1, 7'h19, 2'd2, 1'b0, 1'b0, {7'h40, 7'h12, 7'h7F, 7'h30, 7'h19}, 1'b1};
    vecs[2] = '{ROW_B, ROW_B, 1'b0, 7'h19, 2'd2, 1'b0, 1'b0, {7'h40, 7'h12, 7'h7F, 7'h30, 7'h19}, 1'b1};
    vecs[3] = '{ROW_B, ROW_B, 1'b0, 7'h19, 2'd2, 1'b0, 1'b0, SEG_B, 1'b1};
    vecs[4] = '{ROW_B, ROW_B, 1'b0, 7'h19, 2'd1, 1'b1, 1'b1, SEG_B, 1'b0};
    vecs[5] = '{ROW_B, ROW_B, 1'b0, 7'h19, 2'd1, 1'b1, 1'b1, SEG_BLANK, 1'b1};
    vecs[6] = '{ROW_A, ROW_A, 1'b0, 7'h19, 2'd3, 1'b1, 1'b0, {7'h40, 7'h79, 7'h24, 7'h7F, 7'h19}, 1'b0};
    vecs[7] = '{ROW_A, ROW_A, 1'b0, 7'h19, 2'd3, 1'b0, 1'b1, SEG_A, 1'b1};
`else
    vecs[0] = '{ROW_A, ROW_A, 1'b0, 7'h19, 2'd2, 1'b0, 1'b0, SEG_A, 1'b1};
    vecs[1] = '{ROW_A, ROW_B, 1'b1, 7'h19, 2'd2, 1'b0, 1'b0, SEG_B, 1'b1};
    vecs[2] = '{ROW_B, ROW_B, 1'b0, 7'h19, 2'd2, 1'b0, 1'b0, SEG_B, 1'b1};
    vecs[3] = '{ROW_B, ROW_B, 1'b0, 7'h19, 2'd2, 1'b0, 1'b0, SEG_B, 1'b1};
    vecs[4] = '{ROW_B, ROW_B, 1'b0, 7'h19, 2'd1, 1'b1, 1'b1, SEG_B, 1'b0};
    vecs[5] = '{ROW_B, ROW_B, 1'b0, 7'h19, 2'd1, 1'b1, 1'b1, SEG_B, 1'b0};
    vecs[6] = '{ROW_A, ROW_A, 1'b0, 7'h19, 2'd3, 1'b1, 1'b0, SEG_A, 1'b0};
    vecs[7] = '{ROW_A, ROW_A, 1'b0, 7'h19, 2'd3, 1'b0, 1'b1, SEG_A, 1'b1};
`endif

    RST = 1'b1;
    rowDisp = ROW_A;
    userNumDisp = 7'h19;
    cursorCol = 2'd0;
    wpInd = 1'b0;
    winInd = 1'b0;
    repeat (3) @(negedge CLK);
    checkReset("reset");
    RST = 1'b0;

    prevSeg = SEG_BLANK;
    prevDp = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rowDisp = vecs[i].row;
      userNumDisp = vecs[i].user;
      cursorCol = vecs[i].cur;
      wpInd = vecs[i].wp;
      winInd = vecs[i].win;
      runFrame(prevSeg, prevDp, vecs[i].doMid, vecs[i].mid);
      prevSeg = vecs[i].expSeg;
      prevDp = vecs[i].expDp4;
    end
    runFrame(prevSeg, prevDp, 1'b0, ROW_A);

    // Abort mid-slot 2: outputs return to reset values and the next frame is blank again.
    repeat (9) @(negedge CLK);
    rowDisp = ROW_B;
    wpInd = 1'b1;
    winInd = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    checkReset("midReset");
    RST = 1'b0;
    runFrame(SEG_BLANK, 1'b1, 1'b0, ROW_B);
    runFrame(SEG_B, 1'b0, 1'b0, ROW_B);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
